tmr_voter_monitor: RTL and testbench

Parametrised, registered majority voter for the triple-modular-redundant RISC-V cores. It votes a packed bus of core outputs (PC, ALUResult, RD2, MemWrite; 97 bits by default) from lanes A/B/C. It tracks per-lane disagreement history and permanently excludes a lane that keeps disagreeing, degrading from TMR to duplex. When no safe majority exists, it halts and requests rollback. It sits between the three core replicas and the shared data memory / PC feedback path.

---
 rtl/tmr_voter_monitor_pkg.sv | 25 ++
 rtl/tmr_lane_health.sv | 72 +++++++
 rtl/tmr_voter_monitor.sv | 157 +++++++++++++++
 tb/tb_tmr_voter_monitor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tmr_voter_monitor_pkg.sv
// tmr_pkg: shared encodings for the TMR majority voter and its lane-health trackers.
//   mode_e     - voter operating mode as seen on the mode output
//   EQ_*       - agreement patterns {A==B, B==C, A==C}
//   LANE_*     - bit positions of each lane in 3-bit per-lane vectors {A,B,C}
package tmr_pkg;

    typedef enum logic [1:0] {
        MODE_TRIPLE = 2'b00,
        MODE_DUPLEX = 2'b01,
        MODE_SAFE   = 2'b10
    } mode_e;

    localparam logic [2:0] EQ_ALL   = 3'b111;
    localparam logic [2:0] EQ_C_BAD = 3'b100;
    localparam logic [2:0] EQ_A_BAD = 3'b010;
    localparam logic [2:0] EQ_B_BAD = 3'b001;
    localparam logic [2:0] EQ_NONE  = 3'b000;

    localparam int unsigned LANE_A = 2;
    localparam int unsigned LANE_B = 1;
    localparam int unsigned LANE_C = 0;

    localparam int unsigned CONS_W = 8;

endpackage

// File: rtl/tmr_lane_health.sv
// tmr_lane_health: per-lane disagreement history.
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   suspect_i      - lane was the odd one out this cycle
//   agree_i        - lane took part in a comparison and was not the odd one out
//   freeze_i       - hold all state (no comparison, lane failed, or voter in SAFE)
//   clr_i          - clear consecutive count and fail flag (lifetime count kept)
//   fail_o         - sticky failed flag
//   fail_set_o     - fail flag is being set on this edge
//   err_cnt_o      - saturating lifetime suspect count
module tmr_lane_health
    import tmr_pkg::*;
#(
    parameter int unsigned FaultThresh = 4,
    parameter int unsigned CntW        = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            suspect_i,
    input  logic            agree_i,
    input  logic            freeze_i,
    input  logic            clr_i,
    output logic            fail_o,
    output logic            fail_set_o,
    output logic [CntW-1:0] err_cnt_o
);

    logic [CONS_W-1:0] cons_q, cons_d;
    logic [CntW-1:0]   err_q, err_d;
    logic              fail_q, fail_d;
    logic [CONS_W:0]   cons_inc;

    // Widened so that the threshold compare cannot wrap.
    assign cons_inc = {1'b0, cons_q} + {{CONS_W{1'b0}}, 1'b1};

    always_comb begin
        cons_d     = cons_q;
        err_d      = err_q;
        fail_d     = fail_q;
        fail_set_o = 1'b0;
        if (clr_i) begin
            cons_d = '0;
            fail_d = 1'b0;
        end else if (!freeze_i) begin
            if (suspect_i) begin
                if (cons_q != {CONS_W{1'b1}}) cons_d = cons_inc[CONS_W-1:0];
                if (err_q != {CntW{1'b1}})    err_d  = err_q + {{(CntW-1){1'b0}}, 1'b1};
                if (!fail_q && (cons_inc >= (CONS_W+1)'(FaultThresh))) begin
                    fail_d     = 1'b1;
                    fail_set_o = 1'b1;
                end
            end else if (agree_i) begin
                cons_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cons_q <= '0;
            err_q  <= '0;
            fail_q <= 1'b0;
        end else begin
            cons_q <= cons_d;
            err_q  <= err_d;
            fail_q <= fail_d;
        end
    end

    assign fail_o    = fail_q;
    assign err_cnt_o = err_q;

endmodule

// File: rtl/tmr_voter_monitor.sv
// tmr_voter_monitor: registered majority voter between three core replicas and shared memory.
//   clk, rst_in            - clock, asynchronous active-low reset
//   valid_in               - lanes carry a comparable result
//   lane_a/b/c             - packed core buses {PC, ALUResult, RD2, MemWrite}
//   clr_fail               - clear failed lanes / SAFE, return to TRIPLE
//   data_out, valid_out    - voted bus (1-cycle latency)
//   voter_state            - {A==B, B==C, A==C} of the last compared cycle
//   lane_fail              - sticky failed-lane flags {A,B,C}
//   mode                   - TRIPLE / DUPLEX / SAFE
//   rollback_req           - one-cycle pulse on SAFE entry
//   err_cnt_a/b/c          - saturating lifetime suspect counts
module tmr_voter_monitor
    import tmr_pkg::*;
#(
    parameter int unsigned DW           = 97,
    parameter int unsigned FAULT_THRESH = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             valid_in,
    input  logic [DW-1:0]    lane_a,
    input  logic [DW-1:0]    lane_b,
    input  logic [DW-1:0]    lane_c,
    input  logic             clr_fail,
    output logic [DW-1:0]    data_out,
    output logic             valid_out,
    output logic [2:0]       voter_state,
    output logic [2:0]       lane_fail,
    output logic [1:0]       mode,
    output logic             rollback_req,
    output logic [CNT_W-1:0] err_cnt_a,
    output logic [CNT_W-1:0] err_cnt_b,
    output logic [CNT_W-1:0] err_cnt_c
);

    mode_e         mode_q, mode_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic [2:0]    vs_q, vs_d;
    logic          rb_q, rb_d;

    logic [2:0]    eq;
    logic [2:0]    suspect;
    logic [2:0]    agree;
    logic [2:0]    freeze;
    logic [2:0]    fail_set;
    logic          compare;
    logic [DW-1:0] majority;

    assign eq = {lane_a == lane_b, lane_b == lane_c, lane_a == lane_c};

    // A agrees with at least one other lane, otherwise B and C must be the pair.
    assign majority = (eq[2] || eq[0]) ? lane_a : lane_b;

    assign compare = valid_in && !clr_fail && (mode_q != MODE_SAFE);

    // Single-suspect attribution is only possible with three healthy lanes.
    assign suspect[LANE_A] = (mode_q == MODE_TRIPLE) && (eq == EQ_A_BAD);
    assign suspect[LANE_B] = (mode_q == MODE_TRIPLE) && (eq == EQ_B_BAD);
    assign suspect[LANE_C] = (mode_q == MODE_TRIPLE) && (eq == EQ_C_BAD);
    assign agree           = ~suspect;

    for (genvar i = 0; i < 3; i++) begin : g_lane
        assign freeze[i] = !compare || lane_fail[i];

        tmr_lane_health #(
            .FaultThresh (FAULT_THRESH),
            .CntW        (CNT_W)
        ) u_health (
            .clk_i      (clk),
            .rst_ni     (rst_in),
            .suspect_i  (suspect[i]),
            .agree_i    (agree[i]),
            .freeze_i   (freeze[i]),
            .clr_i      (clr_fail),
            .fail_o     (lane_fail[i]),
            .fail_set_o (fail_set[i]),
            .err_cnt_o  ()
        );
    end

    assign err_cnt_a = g_lane[LANE_A].u_health.err_cnt_o;
    assign err_cnt_b = g_lane[LANE_B].u_health.err_cnt_o;
    assign err_cnt_c = g_lane[LANE_C].u_health.err_cnt_o;

    always_comb begin
        mode_d  = mode_q;
        data_d  = data_q;
        valid_d = 1'b0;
        vs_d    = vs_q;
        rb_d    = 1'b0;
        if (clr_fail) begin
            mode_d = MODE_TRIPLE;
        end else if (compare) begin
            vs_d = eq;
            unique case (mode_q)
                MODE_TRIPLE: begin
                    if (eq == EQ_NONE) begin
                        mode_d = MODE_SAFE;
                        rb_d   = 1'b1;
                    end else begin
                        data_d  = majority;
                        valid_d = 1'b1;
                        if (|fail_set) mode_d = MODE_DUPLEX;
                    end
                end
                MODE_DUPLEX: begin
                    // Healthy pair: whichever two lanes are not flagged.
                    logic          pair_eq;
                    logic [DW-1:0] pair_val;
                    pair_eq  = 1'b0;
                    pair_val = lane_a;
                    if (lane_fail[LANE_A]) begin
                        pair_eq  = eq[1];
                        pair_val = lane_b;
                    end else if (lane_fail[LANE_B]) begin
                        pair_eq  = eq[0];
                    end else begin
                        pair_eq  = eq[2];
                    end
                    if (pair_eq) begin
                        data_d  = pair_val;
                        valid_d = 1'b1;
                    end else begin
                        mode_d = MODE_SAFE;
                        rb_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            mode_q  <= MODE_TRIPLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            vs_q    <= EQ_ALL;
            rb_q    <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            vs_q    <= vs_d;
            rb_q    <= rb_d;
        end
    end

    assign data_out     = data_q;
    assign valid_out    = valid_q;
    assign voter_state  = vs_q;
    assign mode         = mode_q;
    assign rollback_req = rb_q;

endmodule

// File: tb/tb_tmr_voter_monitor.sv
// Directed bench for tmr_voter_monitor with hand-computed expectations.
module tb_tmr_voter_monitor;

    localparam int unsigned DW = 97;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          valid_in;
    logic [DW-1:0] lane_a, lane_b, lane_c;
    logic          clr_fail;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [2:0]    voter_state;
    logic [2:0]    lane_fail;
    logic [1:0]    mode;
    logic          rollback_req;
    logic [CW-1:0] err_cnt_a, err_cnt_b, err_cnt_c;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [DW-1:0] V = 97'h1_0000_0040_0000_0005_0000_0007;

    tmr_voter_monitor #(
        .DW           (DW),
        .FAULT_THRESH (4),
        .CNT_W        (CW)
    ) dut (
        .clk          (clk),
        .rst_in       (rst_in),
        .valid_in     (valid_in),
        .lane_a       (lane_a),
        .lane_b       (lane_b),
        .lane_c       (lane_c),
        .clr_fail     (clr_fail),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .voter_state  (voter_state),
        .lane_fail    (lane_fail),
        .mode         (mode),
        .rollback_req (rollback_req),
        .err_cnt_a    (err_cnt_a),
        .err_cnt_b    (err_cnt_b),
        .err_cnt_c    (err_cnt_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs and return #1 after the rising edge.
    task automatic step(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic v, input logic clr);
        @(negedge clk);
        lane_a   = a;
        lane_b   = b;
        lane_c   = c;
        valid_in = v;
        clr_fail = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " data"},  128'(data_out),     128'(0));
        check({tag, " valid"}, 128'(valid_out),    128'(0));
        check({tag, " vs"},    128'(voter_state),  128'(3'b111));
        check({tag, " fail"},  128'(lane_fail),    128'(0));
        check({tag, " mode"},  128'(mode),         128'(2'b00));
        check({tag, " rb"},    128'(rollback_req), 128'(0));
        check({tag, " erra"},  128'(err_cnt_a),    128'(0));
        check({tag, " errb"},  128'(err_cnt_b),    128'(0));
        check({tag, " errc"},  128'(err_cnt_c),    128'(0));
    endtask

    initial begin
        logic [DW-1:0] vb1, vc2, vb4;
        vb1 = V ^ 97'd1;
        vc2 = V ^ 97'd2;
        vb4 = V ^ 97'd4;

        rst_in = 1'b0; valid_in = 1'b0; clr_fail = 1'b0;
        lane_a = '0; lane_b = '0; lane_c = '0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_in = 1'b1;

        // All agree.
        for (int i = 0; i < 3; i++) begin
            step(V, V, V, 1'b1, 1'b0);
            check("agree valid", 128'(valid_out), 128'(1));
            check("agree data",  128'(data_out), 128'(V));
            check("agree vs",    128'(voter_state), 128'(3'b111));
            check("agree mode",  128'(mode), 128'(2'b00));
        end
        check("agree errs", 128'({err_cnt_a, err_cnt_b, err_cnt_c}), 128'(0));

        // No comparison: output invalid, data held.
        step(vb1, vc2, vb4, 1'b0, 1'b0);
        check("idle valid", 128'(valid_out), 128'(0));
        check("idle data",  128'(data_out), 128'(V));
        check("idle errs",  128'({err_cnt_a, err_cnt_b, err_cnt_c}), 128'(0));

        // Lane B suspect for 3 cycles, then agreement.
        for (int i = 0; i < 3; i++) begin
            step(V, vb1, V, 1'b1, 1'b0);
            check("bsus data", 128'(data_out), 128'(V));
            check("bsus vs",   128'(voter_state), 128'(3'b001));
            check("bsus errb", 128'(err_cnt_b), 128'(i + 1));
        end
        step(V, V, V, 1'b1, 1'b0);
        check("bok vs",   128'(voter_state), 128'(3'b111));
        check("bok errb", 128'(err_cnt_b), 128'(3));
        check("bok fail", 128'(lane_fail), 128'(0));
        check("bok mode", 128'(mode), 128'(2'b00));

        // Lane C corrupted up to the threshold.
        for (int i = 0; i < 3; i++) begin
            step(V, V, vc2, 1'b1, 1'b0);
            check("csus fail", 128'(lane_fail), 128'(0));
            check("csus mode", 128'(mode), 128'(2'b00));
        end
        step(V, V, vc2, 1'b1, 1'b0);
        check("cfail fail", 128'(lane_fail), 128'(3'b001));
        check("cfail mode", 128'(mode), 128'(2'b01));
        check("cfail data", 128'(data_out), 128'(V));
        check("cfail errc", 128'(err_cnt_c), 128'(4));
        step(V, V, vc2, 1'b1, 1'b0);
        check("dup data",  128'(data_out), 128'(V));
        check("dup valid", 128'(valid_out), 128'(1));
        check("dup vs",    128'(voter_state), 128'(3'b100));
        check("dup errc",  128'(err_cnt_c), 128'(4));

        // Duplex pair mismatch -> SAFE.
        step(V, vb4, V, 1'b1, 1'b0);
        check("dsafe rb",    128'(rollback_req), 128'(1));
        check("dsafe mode",  128'(mode), 128'(2'b10));
        check("dsafe valid", 128'(valid_out), 128'(0));
        check("dsafe data",  128'(data_out), 128'(V));
        check("dsafe vs",    128'(voter_state), 128'(3'b001));
        step(vb1, vb1, vb1, 1'b1, 1'b0);
        check("safe rb",    128'(rollback_req), 128'(0));
        check("safe mode",  128'(mode), 128'(2'b10));
        check("safe valid", 128'(valid_out), 128'(0));
        check("safe data",  128'(data_out), 128'(V));
        check("safe errb",  128'(err_cnt_b), 128'(3));

        // Clear back to TRIPLE.
        step(V, V, V, 1'b1, 1'b1);
        check("clr1 mode",  128'(mode), 128'(2'b00));
        check("clr1 fail",  128'(lane_fail), 128'(0));
        check("clr1 valid", 128'(valid_out), 128'(0));
        check("clr1 errc",  128'(err_cnt_c), 128'(4));

        // No majority in TRIPLE.
        step(V, vb1, vc2, 1'b1, 1'b0);
        check("none rb",    128'(rollback_req), 128'(1));
        check("none mode",  128'(mode), 128'(2'b10));
        check("none valid", 128'(valid_out), 128'(0));
        check("none data",  128'(data_out), 128'(V));
        check("none vs",    128'(voter_state), 128'(3'b000));
        step(V, V, V, 1'b1, 1'b0);
        check("none rb2",   128'(rollback_req), 128'(0));
        step(V, V, V, 1'b1, 1'b1);
        check("clr2 mode",  128'(mode), 128'(2'b00));
        check("clr2 fail",  128'(lane_fail), 128'(0));
        check("clr2 valid", 128'(valid_out), 128'(0));
        check("clr2 errs",  128'({err_cnt_a, err_cnt_b, err_cnt_c}),
              128'({8'd0, 8'd3, 8'd4}));

        // Fail C again, then async reset mid-stream.
        for (int i = 0; i < 4; i++) step(V, V, vc2, 1'b1, 1'b0);
        check("dup2 mode", 128'(mode), 128'(2'b01));
        check("dup2 errc", 128'(err_cnt_c), 128'(8));
        @(negedge clk);
        #2;
        rst_in = 1'b0;
        #1;
        check_reset_vals("async");
        @(negedge clk);
        rst_in = 1'b1;
        step(vb1, vb1, vb1, 1'b1, 1'b0);
        check("post data", 128'(data_out), 128'(vb1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
